// File: rtl/fetch_decode_queue.sv
// Two-entry FIFO between fetch and decode with flush, HALT blocking and sticky halted flag.
// Optional decode bubble counter built when FDQ_BUBBLE_CNT_EN is defined.
module fetch_decode_queue #(
   parameter logic [15:0] NOP_WORD = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        f_valid,
   input  logic [15:0] f_instr,
   input  logic [15:0] f_pc_next,
   input  logic        f_err,
   output logic        f_ready,
   input  logic        d_ready,
   input  logic        flush,
   output logic        d_valid,
   output logic [15:0] d_instr,
   output logic [15:0] d_pc_next,
   output logic        d_err,
   output logic        halted,
   output logic [15:0] bubble_cnt
);

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc_next;
      logic        err;
   } entry_t;

   entry_t     mem [2];
   logic       head;
   logic       tail;
   logic [1:0] count;
   logic       halt_seen;
   logic       enq;
   logic       deq;
   entry_t     head_entry;

   assign head_entry = mem[head];
   assign f_ready    = (count < 2'd2) & ~halt_seen & ~halted;
   assign d_valid    = (count != 2'd0);
   assign enq        = f_valid & f_ready & ~flush;
   assign deq        = d_valid & d_ready & ~flush;

   assign d_instr    = d_valid ? head_entry.instr   : NOP_WORD;
   assign d_pc_next  = d_valid ? head_entry.pc_next : 16'h0000;
   assign d_err      = d_valid ? head_entry.err     : 1'b0;

   // NOTE: storage has no reset; outputs are masked by d_valid, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[tail] <= '{instr: f_instr, pc_next: f_pc_next, err: f_err};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         head      <= 1'b0;
         tail      <= 1'b0;
         count     <= 2'd0;
         halt_seen <= 1'b0;
         halted    <= 1'b0;
      end else if (flush) begin
         head      <= 1'b0;
         tail      <= 1'b0;
         count     <= 2'd0;
         halt_seen <= 1'b0;
      end else begin
         if (enq) begin
            tail <= ~tail;
            if ((f_instr == 16'h0000) || f_err) begin
               halt_seen <= 1'b1;
            end
         end
         if (deq) begin
            head <= ~head;
            if (head_entry.instr == 16'h0000) begin
               halted <= 1'b1;
            end
         end
         case ({enq, deq})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

`ifdef FDQ_BUBBLE_CNT_EN
   // Counts cycles with no head word for decode, until the core halts; survives flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt <= 16'h0000;
      end else if (!d_valid && !halted && (bubble_cnt != 16'hFFFF)) begin
         bubble_cnt <= bubble_cnt + 16'd1;
      end
   end
`else
   assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Two-entry instruction queue between the fetch stage and decode in the 16-bit pipelined core. Captures each fetched instruction with its PC+2 and fetch error flag, and presents them in order to decode with a valid/ready handshake. Absorbs decode stalls without dropping words, discards wrong-path words on a branch flush, and blocks further fetch once a HALT (16'h0000) has been queued. Its `f_ready` output drives the fetch stage's PC write enable.

## Interface
- `NOP_WORD`, default 16'h0800: instruction word presented on `d_instr` when no valid entry is at the head.
- `clk` input, 1 bit: core clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset is synchronous and active-high.
- `f_valid` input, 1 bit: fetch presents an instruction this cycle.
- `f_instr` input, 16 bits: fetched instruction, already zeroed by fetch on error.
- `f_pc_next` input, 16 bits: PC+2 of the fetched instruction.
- `f_err` input, 1 bit: instruction memory error for this word.
- `f_ready` output, 1 bit: queue accepts a word this cycle.
- `d_ready` input, 1 bit: decode accepts the head word this cycle (0 = decode stall).
- `flush` input, 1 bit: taken branch or jump; discard all queued and incoming words.
- `d_valid` output, 1 bit: head entry valid.
- `d_instr` output, 16 bits: head instruction, or `NOP_WORD` when `d_valid`=0.
- `d_pc_next` output, 16 bits: head PC+2, or 0 when `d_valid`=0.
- `d_err` output, 1 bit: head error flag, or 0 when `d_valid`=0.
- `halted` output, 1 bit: sticky; a HALT word has been handed to decode.
- `bubble_cnt` output, 16 bits: decode bubble counter (see Configuration).

## Operation
- Storage: 2 entries of {instr[15:0], pc_next[15:0], err}, circular head/tail pointers, 2-bit count (0..2).
- Enqueue = `f_valid & f_ready & ~flush`; dequeue = `d_valid & d_ready & ~flush`.
- `f_ready` = (count < 2) & ~halt_seen & ~halted. It is combinational from registered state only; it never depends on `d_ready`.
- Head outputs are driven from the head entry, so `d_*` depend only on registers.
- halt_seen is set on an enqueue whose `f_instr` == 16'h0000, or whose `f_err` = 1. While set, no further enqueue occurs.
- `halted` is set on a dequeue whose head instr == 16'h0000. It is cleared only by `rst`.
- On `flush`: count is forced to 0, pointers are reset, and halt_seen is cleared. The same-cycle fetch word and the same-cycle dequeue are both discarded, so decode must not act on the head in a flush cycle. `halted` is unaffected.
- Simultaneous enqueue and dequeue: count is unchanged and the pointers both advance. This is legal at count 1. It cannot occur at count 2, because `f_ready`=0 there. At count 0 there is no head, so no dequeue occurs.
- Pointer wrap-around modulo 2; order is strictly FIFO.

## Timing
- Latency: a word enqueued in cycle N is visible on `d_*` with `d_valid`=1 in cycle N+1 at the earliest. There is no combinational bypass.
- Throughput: one word per cycle when `d_ready` is held at 1.
- A decode stall of K cycles with fetch running fills the queue in at most 2 cycles. `f_ready` drops the cycle after count reaches 2.
- Values after reset: count 0, `d_valid` 0, `d_instr` `NOP_WORD`, `d_pc_next` 0, `d_err` 0, `f_ready` 1, `halted` 0, `bubble_cnt` 0, halt_seen 0.
- `rst` asserted mid-operation overrides `flush` and every handshake in that cycle.

## Configuration
- Macro: `FDQ_BUBBLE_CNT_EN`.
- Defined: `bubble_cnt` increments by 1 in each cycle where `d_valid`=0 & `halted`=0 & `rst`=0.
  - It saturates at 16'hFFFF.
  - It is cleared only by `rst`, not by `flush`.
- Not defined: the counter logic is not built, and `bubble_cnt` is tied to 16'h0000.

## Test plan
- Streaming: after reset, present `f_valid`=1 with instrs 16'h4001, 16'h4002, 16'h4003 and PC+2 values 2, 4, 6, with `d_ready`=1.
  - Required: `d_instr` shows 4001, 4002, 4003 in consecutive cycles starting 1 cycle after the first enqueue.
  - Required: `d_pc_next` shows 2, 4, 6, and `f_ready` stays 1.
- Stall: hold `d_ready`=0 while fetching 16'hA001, 16'hA002, 16'hA003.
  - Required: after 2 enqueues `f_ready`=0 and 16'hA003 is not accepted.
  - Required: once `d_ready` returns to 1, decode sees A001, then A002; A003 is accepted on the first cycle `f_ready` is 1 again.
- Flush: with count 2, assert `flush` for 1 cycle while `f_valid`=1 with 16'hB000.
  - Required next cycle: `d_valid`=0, `d_instr`=16'h0800, count 0.
  - Required: B000 never appears on `d_instr`.
- HALT: enqueue 16'h0000 followed by 16'h4005.
  - Required: `f_ready`=0 from the cycle after the HALT enqueue, and 4005 is never queued.
  - Required: after decode accepts HALT, `halted`=1; a later `flush` leaves `halted`=1 and `f_ready`=0.
- Fetch error: enqueue a word with `f_err`=1 and `f_instr`=16'h0000.
  - Required: `d_err`=1 on the head, and halt_seen blocks further enqueue.
  - Required: a `flush` before dequeue clears it, so `d_err`=0 and `f_ready`=1.
- Counter, with `FDQ_BUBBLE_CNT_EN` defined: leave the queue empty for 5 cycles after reset.
  - Required: `bubble_cnt`=5.
  - Required: with the macro undefined, `bubble_cnt` reads 0 throughout.
